// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the riscvCpu data-memory responder.
package riscv_mem_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Word index of a default-width byte address (addr >> 2).
    typedef logic [ADDR_WIDTH_DEF-3:0] word_idx_t;

    typedef enum logic {
        CLEAR,
        RUN
    } dmem_state_e;

endpackage

// File: rtl/dmem_ram_1r1w.sv
// Synchronous RAM, one registered read-first read port and one write port.
module dmem_ram_1r1w #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned AW         = 12
) (
    input  logic                  clk,
    input  logic [AW-1:0]         rdAddr,
    output logic [DATA_WIDTH-1:0] rdData,
    input  logic                  wrEn,
    input  logic [AW-1:0]         wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both assignments are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for riscvCpu: 1-cycle sync RAM with post-reset clear,
// backdoor preload handshake and out-of-range flag.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] memAdr,
    input  logic                  memWE,
    input  logic [DATA_WIDTH-1:0] memwrData,
    output logic [DATA_WIDTH-1:0] memrdData,
    output logic                  memBusy,
    output logic                  memErr,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned RamAw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IdxW-1:0]  DepthIdx = IdxW'(DEPTH_WORDS);
    localparam logic [RamAw-1:0] LastIdx  = RamAw'(DEPTH_WORDS - 1);
    localparam dmem_state_e ResetState = CLEAR_ON_RESET ? CLEAR : RUN;

    dmem_state_e           stateQ, stateD;
    logic [RamAw-1:0]      clrCntQ, clrCntD;
    logic                  rdValidQ;
    logic                  memErrQ;

    logic [IdxW-1:0]       cpuIdx, ldIdx;
    logic                  cpuInRange, ldInRange;

    logic                  ramWe;
    logic [RamAw-1:0]      ramWrAddr;
    logic [DATA_WIDTH-1:0] ramWrData;
    logic [DATA_WIDTH-1:0] ramRdData;

    logic                  unusedAdrBits;
    assign unusedAdrBits = ^{memAdr[1:0], ld_addr[1:0]};

    // Full word index is compared so upper address bits never alias into the array.
    assign cpuIdx     = memAdr[ADDR_WIDTH-1:2];
    assign ldIdx      = ld_addr[ADDR_WIDTH-1:2];
    assign cpuInRange = (cpuIdx < DepthIdx);
    assign ldInRange  = (ldIdx < DepthIdx);

    assign ld_ready = (stateQ == RUN) && !memWE;
    assign memBusy  = reset || (stateQ == CLEAR);

    // Write-port priority: clear sequence, then CPU, then preload.
    always_comb begin
        stateD    = stateQ;
        clrCntD   = clrCntQ;
        ramWe     = 1'b0;
        ramWrAddr = cpuIdx[RamAw-1:0];
        ramWrData = memwrData;
        unique case (stateQ)
            CLEAR: begin
                ramWe     = 1'b1;
                ramWrAddr = clrCntQ;
                ramWrData = '0;
                clrCntD   = clrCntQ + 1'b1;
                if (clrCntQ == LastIdx) begin
                    stateD = RUN;
                end
            end
            RUN: begin
                if (memWE) begin
                    ramWe = cpuInRange;
                end else if (ld_valid) begin
                    ramWe     = ldInRange;
                    ramWrAddr = ldIdx[RamAw-1:0];
                    ramWrData = ld_data;
                end
            end
            default: stateD = ResetState;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= ResetState;
            clrCntQ  <= '0;
            rdValidQ <= 1'b0;
            memErrQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            clrCntQ  <= clrCntD;
            rdValidQ <= (stateQ == RUN) && cpuInRange;
            memErrQ  <= (stateQ == RUN) && !cpuInRange;
        end
    end

    // Masking the RAM output keeps read data at 0 after reset, during clear and out of range.
    assign memrdData = rdValidQ ? ramRdData : '0;
    assign memErr    = memErrQ;

    dmem_ram_1r1w #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH_WORDS),
        .AW        (RamAw)
    ) u_ram (
        .clk   (clk),
        .rdAddr(cpuIdx[RamAw-1:0]),
        .rdData(ramRdData),
        .wrEn  (ramWe),
        .wrAddr(ramWrAddr),
        .wrData(ramWrData)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a 16-word instance for clear/reset timing, a 4096-word one for addressing.
module tb_dmem_responder;

    logic        clk;
    logic        sReset, sWE, sLdValid, sLdReady, sBusy, sErr;
    logic [31:0] sAdr, sWr, sRd, sLdAddr, sLdData;
    logic        bReset, bWE, bLdValid, bLdReady, bBusy, bErr;
    logic [31:0] bAdr, bWr, bRd, bLdAddr, bLdData;

    int checks = 0;
    int passes = 0;

    dmem_responder #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .DEPTH_WORDS   (16),
        .CLEAR_ON_RESET(1'b1)
    ) u_small (
        .clk      (clk),
        .reset    (sReset),
        .memAdr   (sAdr),
        .memWE    (sWE),
        .memwrData(sWr),
        .memrdData(sRd),
        .memBusy  (sBusy),
        .memErr   (sErr),
        .ld_valid (sLdValid),
        .ld_ready (sLdReady),
        .ld_addr  (sLdAddr),
        .ld_data  (sLdData)
    );

    dmem_responder #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .DEPTH_WORDS   (4096),
        .CLEAR_ON_RESET(1'b1)
    ) u_big (
        .clk      (clk),
        .reset    (bReset),
        .memAdr   (bAdr),
        .memWE    (bWE),
        .memwrData(bWr),
        .memrdData(bRd),
        .memBusy  (bBusy),
        .memErr   (bErr),
        .ld_valid (bLdValid),
        .ld_ready (bLdReady),
        .ld_addr  (bLdAddr),
        .ld_data  (bLdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles starting with the current one; reset is released after the first edge.
    task automatic count_busy_small(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            if (!sBusy) break;
            n++;
            tick();
            sReset = 1'b0;
        end
    endtask

    task automatic count_busy_big(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            if (!bBusy) break;
            n++;
            tick();
            bReset = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        count_busy_small(40, n);
        checks++;
        if (n !== 17) $display("FAIL small_busy_cycles: got %0d expected 17", n);
        else passes++;
        checks++;
        if (sBusy !== 1'b0 || sLdReady !== 1'b1 || sErr !== 1'b0)
            $display("FAIL small_run_flags: busy=%b ld_ready=%b err=%b expected 0 1 0",
                     sBusy, sLdReady, sErr);
        else passes++;
    endtask

    task automatic test_clear_reads_zero();
        for (int i = 0; i < 16; i++) begin
            sAdr = 32'(i * 4);
            tick();
            checks++;
            if (sRd !== 32'h0) $display("FAIL clear_read_w%0d: got %h expected 0", i, sRd);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        sAdr = 32'h28;
        sWE  = 1'b1;
        sWr  = 32'hdeadbeef;
        tick();
        checks++;
        if (sRd !== 32'h0) $display("FAIL small_read_first: got %h expected 0", sRd);
        else passes++;
        sWE = 1'b0;
        tick();
        checks++;
        if (sRd !== 32'hdeadbeef) $display("FAIL small_write: got %h expected deadbeef", sRd);
        else passes++;
        sReset = 1'b1;
        tick();
        sReset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (sBusy !== 1'b1) $display("FAIL busy_at_cnt5: got %b expected 1", sBusy);
        else passes++;
        sReset = 1'b1;
        count_busy_small(40, n);
        checks++;
        if (n !== 17) $display("FAIL restart_busy_cycles: got %0d expected 17", n);
        else passes++;
        tick();
        checks++;
        if (sRd !== 32'h0) $display("FAIL word10_cleared: got %h expected 0", sRd);
        else passes++;
    endtask

    task automatic test_big_reset();
        int n;
        checks++;
        if (bRd !== 32'h0 || bErr !== 1'b0 || bLdReady !== 1'b0)
            $display("FAIL big_reset_outputs: rd=%h err=%b ld_ready=%b expected 0 0 0",
                     bRd, bErr, bLdReady);
        else passes++;
        count_busy_big(5000, n);
        checks++;
        if (n !== 4097) $display("FAIL big_busy_cycles: got %0d expected 4097", n);
        else passes++;
        bAdr = 32'h2114;
        tick();
        checks++;
        if (bRd !== 32'h0) $display("FAIL big_clear_read: got %h expected 0", bRd);
        else passes++;
    endtask

    task automatic test_preload();
        bAdr     = 32'h0;
        bLdValid = 1'b1;
        bLdAddr  = 32'h2114;
        bLdData  = 32'h00ff00ff;
        #1;
        checks++;
        if (bLdReady !== 1'b1) $display("FAIL preload_ready: got %b expected 1", bLdReady);
        else passes++;
        tick();
        bLdAddr = 32'h208c;
        bLdData = 32'h12345678;
        tick();
        bLdAddr = 32'h0;
        bLdData = 32'h01020304;
        tick();
        bLdValid = 1'b0;
        bAdr     = 32'h2114;
        tick();
        checks++;
        if (bRd !== 32'h00ff00ff || bErr !== 1'b0)
            $display("FAIL preload_read: rd=%h err=%b expected 00ff00ff 0", bRd, bErr);
        else passes++;
    endtask

    task automatic test_rw_same_cycle();
        bAdr = 32'h208c;
        bWE  = 1'b1;
        bWr  = 32'hff00ff00;
        tick();
        checks++;
        if (bRd !== 32'h12345678) $display("FAIL rw_old_data: got %h expected 12345678", bRd);
        else passes++;
        bWE = 1'b0;
        tick();
        checks++;
        if (bRd !== 32'hff00ff00) $display("FAIL rw_new_data: got %h expected ff00ff00", bRd);
        else passes++;
    endtask

    task automatic test_contention();
        bAdr     = 32'h10;
        bWE      = 1'b1;
        bWr      = 32'haaaa5555;
        bLdValid = 1'b1;
        bLdAddr  = 32'h20;
        bLdData  = 32'h5a5a5a5a;
        #1;
        checks++;
        if (bLdReady !== 1'b0) $display("FAIL contend_ready_low: got %b expected 0", bLdReady);
        else passes++;
        tick();
        bWE  = 1'b0;
        bAdr = 32'h20;
        #1;
        checks++;
        if (bLdReady !== 1'b1) $display("FAIL contend_ready_high: got %b expected 1", bLdReady);
        else passes++;
        tick();
        checks++;
        if (bRd !== 32'h0) $display("FAIL preload_read_first: got %h expected 0", bRd);
        else passes++;
        bLdValid = 1'b0;
        tick();
        checks++;
        if (bRd !== 32'h5a5a5a5a) $display("FAIL preload_landed: got %h expected 5a5a5a5a", bRd);
        else passes++;
        bAdr = 32'h10;
        tick();
        checks++;
        if (bRd !== 32'haaaa5555) $display("FAIL cpu_write_landed: got %h expected aaaa5555", bRd);
        else passes++;
    endtask

    task automatic test_out_of_range();
        bAdr = 32'h4000;
        bWE  = 1'b1;
        bWr  = 32'hbad0bad0;
        tick();
        checks++;
        if (bRd !== 32'h0 || bErr !== 1'b1)
            $display("FAIL oor_read: rd=%h err=%b expected 0 1", bRd, bErr);
        else passes++;
        bWE  = 1'b0;
        bAdr = 32'h0;
        tick();
        checks++;
        if (bErr !== 1'b0 || bRd !== 32'h01020304)
            $display("FAIL oor_no_alias: rd=%h err=%b expected 01020304 0", bRd, bErr);
        else passes++;
        bLdValid = 1'b1;
        bLdAddr  = 32'h4000;
        bLdData  = 32'hcafef00d;
        #1;
        checks++;
        if (bLdReady !== 1'b1) $display("FAIL oor_preload_ready: got %b expected 1", bLdReady);
        else passes++;
        tick();
        bLdValid = 1'b0;
        tick();
        checks++;
        if (bErr !== 1'b0 || bRd !== 32'h01020304)
            $display("FAIL oor_preload_dropped: rd=%h err=%b expected 01020304 0", bRd, bErr);
        else passes++;
    endtask

    initial begin
        sReset = 1'b1; sWE = 1'b0; sWr = '0; sAdr = '0;
        sLdValid = 1'b0; sLdAddr = '0; sLdData = '0;
        bReset = 1'b1; bWE = 1'b0; bWr = '0; bAdr = '0;
        bLdValid = 1'b0; bLdAddr = '0; bLdData = '0;
        #1;
        test_reset();
        test_clear_reads_zero();
        test_reset_mid_clear();
        test_big_reset();
        test_preload();
        test_rw_same_cycle();
        test_contention();
        test_out_of_range();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
